// File: rtl/avl_ram_slave_if.sv
// avl_ram_slave_if: word-oriented request/response bus shared by the RAM slave and its masters
interface i_avl_bus;
  logic [31:0] address;
  logic [3:0]  byte_en;
  logic        read;
  logic        write;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_data_valid;
  logic        request_ready;
  modport master (
    output address, byte_en, read, write, write_data,
    input  read_data, read_data_valid, request_ready
  );
  modport slave (
    input  address, byte_en, read, write, write_data,
    output read_data, read_data_valid, request_ready
  );
endinterface

// File: rtl/avl_ram_slave.sv
// avl_ram_slave: on-chip RAM slave with byte-enabled writes, fixed-latency in-order reads; AVL_RAM_STALL_EN adds LFSR stall injection
module avl_ram_slave #(
  parameter int          SIZE_WORDS   = 8192,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF,
  parameter              INIT_FILE    = ""
) (
  input logic     clk,
  input logic     rest,
  i_avl_bus.slave avl_s0
);
  localparam int AW = $clog2(SIZE_WORDS);
  localparam logic [32:0] LIMIT = 33'(SIZE_WORDS) << 2;
  logic [31:0]   mem [SIZE_WORDS];
  logic          ready;
  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          acc_rd;
  logic          acc_wr;
  logic          sv [READ_LATENCY];
  logic [31:0]   sd [READ_LATENCY];
  assign off      = avl_s0.address - BASE_ADDR;
  assign in_range = {1'b0, off} < LIMIT;
  assign idx      = off[AW+1:2];
  assign acc_wr   = ready & avl_s0.write;
  assign acc_rd   = ready & avl_s0.read & ~avl_s0.write;
  assign avl_s0.request_ready   = ready;
  assign avl_s0.read_data_valid = sv[READ_LATENCY-1];
  assign avl_s0.read_data       = sd[READ_LATENCY-1];
  always_ff @(posedge clk) begin
    if (acc_wr && in_range)
      for (int i = 0; i < 4; i++)
        if (avl_s0.byte_en[i]) mem[idx][8*i +: 8] <= avl_s0.write_data[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        sv[i] <= 1'b0;
        sd[i] <= '0;
      end
    end else begin
      sv[0] <= acc_rd;
      if (acc_rd) sd[0] <= in_range ? mem[idx] : ERR_DATA;
      for (int i = 1; i < READ_LATENCY; i++) begin
        sv[i] <= sv[i-1];
        if (sv[i-1]) sd[i] <= sd[i-1];
      end
    end
  end
`ifdef AVL_RAM_STALL_EN
  logic [7:0] lfsr;
  logic [7:0] lfsr_nx;
  assign lfsr_nx = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      lfsr  <= 8'hA5;
      ready <= 1'b0;
    end else begin
      lfsr  <= lfsr_nx;
      ready <= lfsr_nx[2:0] != 3'b000;
    end
  end
`else
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) ready <= 1'b0;
    else       ready <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_avl_ram_slave.sv
// tb_avl_ram_slave: table-driven and sequence checks of avl_ram_slave (READ_LATENCY=3, 256 words at 0x1000)
module tb_avl_ram_slave;
  localparam int          LAT = 3;
  localparam logic [31:0] B   = 32'h0000_1000;
  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ex;
  } vec_t;
  logic clk = 1'b0;
  logic rest = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   stalls = 0;
  int   exp_c[$];
  int   rsp_c[$];
  logic [31:0] exp_d[$];
  logic [31:0] rsp_d[$];
  vec_t tbl[$];
  logic [31:0] model [16];
  i_avl_bus bus();
  avl_ram_slave #(.SIZE_WORDS(256), .BASE_ADDR(B), .READ_LATENCY(LAT)) dut (
    .clk(clk), .rest(rest), .avl_s0(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (bus.read_data_valid === 1'b1) begin
      rsp_c.push_back(cyc);
      rsp_d.push_back(bus.read_data);
    end
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask
  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [3:0] be, input logic [31:0] wd, input logic [31:0] ex);
    vec_t v;
    v.r = r; v.w = w; v.a = a; v.be = be; v.wd = wd; v.ex = ex;
    return v;
  endfunction
  task automatic issue(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd, output int acc);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.read = r; bus.write = w; bus.address = a; bus.byte_en = be; bus.write_data = wd;
    for (int k = 0; k < 64 && !ok; k++) begin
      if (k > 0) @(negedge clk);
      ok = bus.request_ready;
      if (!ok) stalls++;
      @(posedge clk);
    end
    #1;
    acc = cyc;
    bus.read = 1'b0;
    bus.write = 1'b0;
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask
  task automatic expect_rd(input int acc, input logic [31:0] d);
    exp_c.push_back(acc + LAT - 1);
    exp_d.push_back(d);
  endtask
  task automatic drain(input string nm);
    repeat (LAT + 3) @(negedge clk);
    #1;
    while (exp_d.size() > 0) begin
      if (rsp_d.size() == 0) begin
        check({nm, "_missing"}, {32'(exp_c.pop_front()), exp_d.pop_front()}, 64'd0);
      end else begin
        check(nm, {32'(rsp_c.pop_front()), rsp_d.pop_front()},
                  {32'(exp_c.pop_front()), exp_d.pop_front()});
      end
    end
    check({nm, "_extra"}, 64'(rsp_d.size()), 64'd0);
    rsp_c.delete();
    rsp_d.delete();
  endtask
  initial begin
    int acc;
    int k;
    logic r;
    logic oor;
    logic [3:0] be;
    logic [31:0] wd;
    logic [31:0] a;
    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.byte_en = '0; bus.write_data = '0;
    tbl.push_back(mk(1'b0, 1'b1, B + 32'h10,  4'hF, 32'h1234_5678, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, B + 32'h10,  4'h0, 32'h0,         32'h1234_5678));
    tbl.push_back(mk(1'b0, 1'b1, B + 32'h20,  4'hF, 32'hAABB_CCDD, 32'h0));
    tbl.push_back(mk(1'b0, 1'b1, B + 32'h20,  4'h2, 32'h0000_1100, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, B + 32'h20,  4'h0, 32'h0,         32'hAABB_11DD));
    tbl.push_back(mk(1'b0, 1'b1, B + 32'h24,  4'hF, 32'h0000_0000, 32'h0));
    tbl.push_back(mk(1'b0, 1'b1, B + 32'h24,  4'h9, 32'hA1B2_C3D4, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, B + 32'h24,  4'h0, 32'h0,         32'hA100_00D4));
    tbl.push_back(mk(1'b0, 1'b1, B,           4'hF, 32'h600D_600D, 32'h0));
    tbl.push_back(mk(1'b0, 1'b1, B + 32'h400, 4'hF, 32'h5555_5555, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, B,           4'h0, 32'h0,         32'h600D_600D));
    tbl.push_back(mk(1'b1, 1'b0, B + 32'h400, 4'h0, 32'h0,         32'hDEAD_BEEF));
    tbl.push_back(mk(1'b0, 1'b1, B + 32'h3FC, 4'hF, 32'h7777_7777, 32'h0));
    tbl.push_back(mk(1'b0, 1'b1, B - 32'h4,   4'hF, 32'h9999_9999, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, B + 32'h3FC, 4'h0, 32'h0,         32'h7777_7777));
    tbl.push_back(mk(1'b1, 1'b0, B - 32'h4,   4'h0, 32'h0,         32'hDEAD_BEEF));
    tbl.push_back(mk(1'b1, 1'b0, B + 32'h13,  4'h0, 32'h0,         32'h1234_5678));
    tbl.push_back(mk(1'b1, 1'b1, B + 32'h10,  4'hF, 32'hCAFE_F00D, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, B + 32'h10,  4'h0, 32'h0,         32'hCAFE_F00D));
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 64'(bus.request_ready), 64'd0);
    check("rst_valid", 64'(bus.read_data_valid), 64'd0);
    check("rst_data", 64'(bus.read_data), 64'd0);
    rest = 1'b1;
    #1;
    check("ready_before_edge", 64'(bus.request_ready), 64'd0);
    @(negedge clk);
    check("ready_after_edge", 64'(bus.request_ready), 64'd1);
    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].be, tbl[i].wd, acc);
      if (tbl[i].r && !tbl[i].w) expect_rd(acc, tbl[i].ex);
    end
    drain("tbl");
    for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, B + 32'(4 * i), 4'hF, 32'(i + 1), acc);
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, B + 32'(4 * i), 4'h0, 32'h0, acc);
      expect_rd(acc, 32'(i + 1));
    end
    drain("pipe");
    check("hold_data", {31'd0, bus.read_data_valid, bus.read_data}, {32'd0, 32'd4});
    issue(1'b1, 1'b0, B + 32'h10, 4'h0, 32'h0, acc);
    @(negedge clk);
    rest = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.read_data_valid), 64'd0);
    check("midrst_ready", 64'(bus.request_ready), 64'd0);
    repeat (2) @(negedge clk);
    rest = 1'b1;
    #1;
    check("rel_ready_low", 64'(bus.request_ready), 64'd0);
    @(negedge clk);
    check("rel_ready_high", 64'(bus.request_ready), 64'd1);
    repeat (LAT + 2) @(negedge clk);
    #1;
    check("midrst_no_pulse", 64'(rsp_d.size()), 64'd0);
    rsp_c.delete();
    rsp_d.delete();
    issue(1'b1, 1'b0, B + 32'h10, 4'h0, 32'h0, acc);
    expect_rd(acc, 32'hCAFE_F00D);
    drain("ram_kept");
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      issue(1'b0, 1'b1, B + 32'(4 * i), 4'hF, model[i], acc);
    end
    for (int n = 0; n < 300; n++) begin
      k   = $urandom_range(0, 15);
      r   = 1'($urandom_range(0, 1));
      oor = $urandom_range(0, 9) == 0;
      be  = 4'($urandom);
      wd  = $urandom;
      a   = B + 32'(4 * k) + (oor ? 32'h400 : 32'h0) + 32'($urandom_range(0, 3));
      issue(r, ~r, a, be, wd, acc);
      if (r) expect_rd(acc, oor ? 32'hDEAD_BEEF : model[k]);
      else if (!oor)
        for (int j = 0; j < 4; j++) if (be[j]) model[k][8*j +: 8] = wd[8*j +: 8];
    end
    drain("rand");
`ifdef AVL_RAM_STALL_EN
    check("stall_seen", 64'(stalls > 0), 64'd1);
`else
    check("no_stall", 64'(stalls), 64'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
